// File: rtl/piso_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx_arbiter
// Description : Two-requester round-robin scheduler sharing one PISO shift
//               register. Each granted word leaves as a framed serial burst:
//               start bit (0), WIDTH data bits LSB first, stop bit (1).
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx_arbiter #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             so,
    output logic             so_valid,
    output logic             busy,
    output logic             grant_id
);

    // Counter widths and terminal counts
    localparam int c_cyc_w = $clog2(DIV + 1);
    localparam int c_bit_w = $clog2(WIDTH + 1);

    localparam logic [c_cyc_w-1:0] c_cyc_last = c_cyc_w'(DIV - 1);
    localparam logic [c_cyc_w-1:0] c_cyc_one  = c_cyc_w'(1);
    localparam logic [c_cyc_w-1:0] c_cyc_zero = '0;
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WIDTH - 1);
    localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);
    localparam logic [c_bit_w-1:0] c_bit_zero = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_cyc_w-1:0] r_cyc_cnt;
    logic [c_cyc_w-1:0] w_cyc_cnt_next;
    logic [c_bit_w-1:0] r_bit_cnt;
    logic [c_bit_w-1:0] w_bit_cnt_next;
    logic [WIDTH-1:0]   r_shreg;
    logic [WIDTH-1:0]   w_shreg_next;
    logic               r_last;        // index of the last-served requester
    logic               w_idle_ok;
    logic               w_pick1;
    logic               w_hs;
    logic               w_hs_id;
    logic               w_cyc_end;

    // Round-robin arbitration and combinational ready/handshake generation
    always_comb begin
        w_idle_ok  = rst_n & (r_state == IDLE);
        // Requester 1 wins when it is alone, or on a tie when 0 was served last
        w_pick1    = req1_valid & (~req0_valid | ~r_last);
        req0_ready = w_idle_ok & req0_valid & ~w_pick1;
        req1_ready = w_idle_ok & w_pick1;
        w_hs       = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        w_hs_id    = req1_ready;
    end

    // Next-state, shift-register and counter logic
    always_comb begin
        w_state_next   = r_state;
        w_cyc_cnt_next = r_cyc_cnt;
        w_bit_cnt_next = r_bit_cnt;
        w_shreg_next   = r_shreg;
        w_cyc_end      = (r_cyc_cnt == c_cyc_last);

        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_state_next = START;
                    w_shreg_next = w_hs_id ? req1_data : req0_data;
                end
            end
            START: begin
                if (w_cyc_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                if (w_cyc_end) begin
                    // Bit 0 has been presented for DIV cycles; expose the next one
                    w_shreg_next = r_shreg >> 1;
                    if (r_bit_cnt == c_bit_last) begin
                        w_state_next = STOP;
                    end
                end
            end
            STOP: begin
                if (w_cyc_end) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase

        // Both counters restart on every state entry; otherwise the cycle
        // counter runs to DIV-1 and the bit counter advances per data bit.
        if (w_state_next != r_state) begin
            w_cyc_cnt_next = c_cyc_zero;
            w_bit_cnt_next = c_bit_zero;
        end else if (r_state != IDLE) begin
            if (w_cyc_end) begin
                w_cyc_cnt_next = c_cyc_zero;
                if (r_state == DATA) begin
                    w_bit_cnt_next = r_bit_cnt + c_bit_one;
                end
            end else begin
                w_cyc_cnt_next = r_cyc_cnt + c_cyc_one;
            end
        end
    end

    // State, counter and shift-register registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cyc_cnt <= c_cyc_zero;
            r_bit_cnt <= c_bit_zero;
            r_shreg   <= '0;
        end else begin
            r_state   <= w_state_next;
            r_cyc_cnt <= w_cyc_cnt_next;
            r_bit_cnt <= w_bit_cnt_next;
            r_shreg   <= w_shreg_next;
        end
    end

    // Arbitration pointer and grant source, updated only on a handshake
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_last   <= 1'b1;
            grant_id <= 1'b0;
        end else if (w_hs) begin
            r_last   <= w_hs_id;
            grant_id <= w_hs_id;
        end
    end

    // Registered line outputs, derived from the state being entered so they
    // change on the same edge as the state itself
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            so       <= 1'b1;
            so_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            so       <= (w_state_next == DATA) ? w_shreg_next[0]
                                               : (w_state_next != START);
            so_valid <= (w_state_next == DATA);
            busy     <= (w_state_next != IDLE);
        end
    end

    // The arbiter never offers both ports at once
    a_one_ready : assert property (@(posedge clk) !(req0_ready && req1_ready));

endmodule
`default_nettype wire

// File: tb/tb_piso_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx_arbiter
// Description : Scoreboard bench for piso_tx_arbiter. Instance a uses DIV=1,
//               instance b uses DIV=3; both WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx_arbiter;

    logic       clk;
    logic       a_rst_n, b_rst_n;
    logic       a_req0_valid, a_req1_valid, a_req0_ready, a_req1_ready;
    logic [3:0] a_req0_data, a_req1_data;
    logic       a_so, a_so_valid, a_busy, a_grant_id;
    logic       b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [3:0] b_req0_data, b_req1_data;
    logic       b_so, b_so_valid, b_busy, b_grant_id;

    int n_checks = 0;
    int n_fail   = 0;

    logic exp_bits[$];
    logic exp_gid[$];
    logic a_busy_q = 1'b0;

    piso_tx_arbiter #(.WIDTH(4), .DIV(1)) dut_a (
        .clk(clk), .rst_n(a_rst_n),
        .req0_valid(a_req0_valid), .req0_data(a_req0_data), .req0_ready(a_req0_ready),
        .req1_valid(a_req1_valid), .req1_data(a_req1_data), .req1_ready(a_req1_ready),
        .so(a_so), .so_valid(a_so_valid), .busy(a_busy), .grant_id(a_grant_id)
    );

    piso_tx_arbiter #(.WIDTH(4), .DIV(3)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .req0_valid(b_req0_valid), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
        .so(b_so), .so_valid(b_so_valid), .busy(b_busy), .grant_id(b_grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Queue the expected serial bits (LSB first) and grant source of one frame
    task automatic push_word(input logic [3:0] d, input logic id);
        for (int i = 0; i < 4; i++) exp_bits.push_back(d[i]);
        exp_gid.push_back(id);
    endtask

    // Record instance-a outputs over n cycles, oldest sample in the MSB
    task automatic capture(input int n, output logic [31:0] so_t, output logic [31:0] sv_t,
                           output logic [31:0] bz_t, output logic [31:0] r0_t,
                           output logic [31:0] r1_t);
        so_t = '0; sv_t = '0; bz_t = '0; r0_t = '0; r1_t = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            so_t = (so_t << 1) | 32'(a_so);
            sv_t = (sv_t << 1) | 32'(a_so_valid);
            bz_t = (bz_t << 1) | 32'(a_busy);
            r0_t = (r0_t << 1) | 32'(a_req0_ready);
            r1_t = (r1_t << 1) | 32'(a_req1_ready);
        end
    endtask

    // Monitor: compare grant_id at each frame start and every data bit
    always @(negedge clk) begin
        if (a_busy && !a_busy_q) begin
            if (exp_gid.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL grant_id_unexpected: got frame with grant_id %0d, expected none", a_grant_id);
            end else begin
                check("grant_id", 32'(a_grant_id), 32'(exp_gid.pop_front()));
            end
        end
        if (a_so_valid) begin
            if (exp_bits.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL data_bit_unexpected: got bit %0d, expected none", a_so);
            end else begin
                check("data_bit", 32'(a_so), 32'(exp_bits.pop_front()));
            end
        end
        a_busy_q = a_busy;
    end

    initial begin
        logic [31:0] so_t, sv_t, bz_t, r0_t, r1_t;
        logic [31:0] hs_ids, hs_at;
        int          hs_n, both, b_busy_n, b_sv_n;

        a_rst_n = 1'b0; b_rst_n = 1'b0;
        a_req0_valid = 1'b1; a_req0_data = 4'h0; a_req1_valid = 1'b0; a_req1_data = 4'h0;
        b_req0_valid = 1'b0; b_req0_data = 4'h0; b_req1_valid = 1'b1; b_req1_data = 4'h0;

        // Reset values, with requests pending that must not be accepted
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_so", 32'(a_so), 32'd1);
        check("reset_so_valid", 32'(a_so_valid), 32'd0);
        check("reset_busy", 32'(a_busy), 32'd0);
        check("reset_grant_id", 32'(a_grant_id), 32'd0);
        check("reset_ready0", 32'(a_req0_ready), 32'd0);
        check("reset_b_ready1", 32'(b_req1_ready), 32'd0);
        @(posedge clk); #1;
        a_req0_valid = 1'b0; b_req1_valid = 1'b0;
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        @(posedge clk); #1;

        // Single word from requester 0: 4'b1011
        a_req0_valid = 1'b1; a_req0_data = 4'b1011;
        push_word(4'b1011, 1'b0);
        @(negedge clk);
        check("t1_ready0", 32'(a_req0_ready), 32'd1);
        check("t1_ready1", 32'(a_req1_ready), 32'd0);
        @(posedge clk); #1;
        a_req0_valid = 1'b0;
        capture(7, so_t, sv_t, bz_t, r0_t, r1_t);
        check("t1_so_trace", so_t, 32'b0110111);
        check("t1_so_valid_trace", sv_t, 32'b0111100);
        check("t1_busy_trace", bz_t, 32'b1111110);
        check("t1_ready0_trace", r0_t, 32'd0);

        // Reset again so requester 0 wins the first tie
        @(posedge clk); #1;
        a_rst_n = 1'b0;
        @(posedge clk); #1;
        a_rst_n = 1'b1;

        // Both requesters valid continuously: grants 0,1,0,1 seven cycles apart
        a_req0_valid = 1'b1; a_req0_data = 4'hA;
        a_req1_valid = 1'b1; a_req1_data = 4'h5;
        push_word(4'hA, 1'b0); push_word(4'h5, 1'b1);
        push_word(4'hA, 1'b0); push_word(4'h5, 1'b1);
        hs_n = 0; hs_ids = '0; hs_at = '0; both = 0;
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            if (a_req0_ready && a_req1_ready) both++;
            if (a_req0_ready || a_req1_ready) begin
                hs_n++;
                hs_ids = (hs_ids << 1) | 32'(a_req1_ready);
                hs_at  = (hs_at << 8) | 32'(i);
            end
        end
        @(posedge clk); #1;
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
        check("t2_handshake_count", 32'(hs_n), 32'd4);
        check("t2_grant_order", hs_ids, 32'b0101);
        check("t2_handshake_cycles", hs_at, 32'h00070E15);
        check("t2_both_ready", 32'(both), 32'd0);
        @(posedge clk); #1;

        // Data changed the cycle after the handshake is not used
        a_req0_valid = 1'b1; a_req0_data = 4'h3;
        push_word(4'h3, 1'b0);
        @(negedge clk);
        check("t4_ready0", 32'(a_req0_ready), 32'd1);
        @(posedge clk); #1;
        a_req0_valid = 1'b0; a_req0_data = 4'hC;
        repeat (7) @(posedge clk);
        #1;

        // Reset during data bit 2, with a new request pending
        a_req0_valid = 1'b1; a_req0_data = 4'b0100;
        push_word(4'b0100, 1'b0);
        @(negedge clk);
        check("t5_ready0", 32'(a_req0_ready), 32'd1);
        @(posedge clk); #1;
        a_req0_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        a_rst_n = 1'b0; a_req0_valid = 1'b1; a_req0_data = 4'h9;
        @(negedge clk);
        check("t5_in_bit2", 32'(a_so_valid), 32'd1);
        check("t5_ready_in_reset", 32'(a_req0_ready), 32'd0);
        @(posedge clk); #1;
        a_rst_n = 1'b1;
        exp_bits.delete();
        push_word(4'h9, 1'b0);
        @(negedge clk);
        check("t5_abort_so", 32'(a_so), 32'd1);
        check("t5_abort_busy", 32'(a_busy), 32'd0);
        check("t5_abort_so_valid", 32'(a_so_valid), 32'd0);
        check("t5_ready_after_reset", 32'(a_req0_ready), 32'd1);
        @(posedge clk); #1;
        a_req0_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;

        // Requester 1 alone, back to back: one IDLE cycle between frames
        a_req1_valid = 1'b1; a_req1_data = 4'h6;
        push_word(4'h6, 1'b1); push_word(4'h6, 1'b1);
        capture(14, so_t, sv_t, bz_t, r0_t, r1_t);
        @(posedge clk); #1;
        a_req1_valid = 1'b0;
        check("t6_busy_trace", bz_t, 32'b01111110111111);
        check("t6_ready1_trace", r1_t, 32'b10000001000000);
        check("t6_ready0_trace", r0_t, 32'd0);
        repeat (7) @(posedge clk);
        #1;

        // DIV=3 instance, requester 1 word 4'h6
        b_req1_valid = 1'b1; b_req1_data = 4'h6;
        @(negedge clk);
        check("b_ready1", 32'(b_req1_ready), 32'd1);
        @(posedge clk); #1;
        b_req1_valid = 1'b0;
        so_t = '0; sv_t = '0; bz_t = '0; b_busy_n = 0; b_sv_n = 0;
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            so_t = (so_t << 1) | 32'(b_so);
            sv_t = (sv_t << 1) | 32'(b_so_valid);
            bz_t = (bz_t << 1) | 32'(b_busy);
            if (b_busy) b_busy_n++;
            if (b_so_valid) b_sv_n++;
        end
        check("b_so_trace", so_t, 32'b000_000_111_111_000_111_1);
        check("b_so_valid_trace", sv_t, 32'b000_111111111111_000_0);
        check("b_busy_trace", bz_t, 32'b111111111111111111_0);
        check("b_busy_cycles", 32'(b_busy_n), 32'd18);
        check("b_so_valid_cycles", 32'(b_sv_n), 32'd12);
        check("b_grant_id", 32'(b_grant_id), 32'd1);

        // Every expected bit and frame must have been observed
        check("scoreboard_bits_left", 32'(exp_bits.size()), 32'd0);
        check("scoreboard_frames_left", 32'(exp_gid.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piso_tx_arbiter.md
# piso_tx_arbiter

Two-requester serial transmit scheduler. It owns one WIDTH-bit parallel-in/serial-out shift register and shares it between two parallel-word sources using round-robin arbitration. Each granted word is sequenced as a framed serial burst: start bit, WIDTH data bits LSB first, stop bit. The block sits between the parallel producers and the single-wire serial output.

## Interface
- WIDTH, 4, data word width in bits; must be ≥1.
- DIV, 1, clock cycles per serial bit; must be ≥1 (DIV=0 is illegal).

- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, synchronous and active-low.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle.
- so  output  1  serial line, registered; idle level is 1.
- so_valid  output  1  registered; high while so carries a data bit.
- busy  output  1  registered; high from START through STOP.
- grant_id  output  1  registered; source of the current or last frame.

## Operation
- FSM states: IDLE, START, DATA, STOP.
  - IDLE → START on a handshake.
  - START → DATA after DIV cycles.
  - DATA → STOP after WIDTH×DIV cycles.
  - STOP → IDLE after DIV cycles.
- Handshakes:
  - Handshake on port N = reqN_valid & reqN_ready.
  - readyN is combinational and is high only in IDLE with rst_n=1.
  - At most one ready is high per cycle.
  - A requester may drop valid without a handshake; nothing is latched unless there is a handshake.
- Arbitration (round-robin):
  - A one-bit last-served pointer; reset value 1, so requester 0 wins the first tie.
  - One valid: that requester is granted.
  - Both valid: the requester other than last-served is granted.
  - The pointer updates on each handshake.
- Handshake effects:
  - The granted word is loaded into the shift register.
  - grant_id is set to the granted index.
  - reqN_data is ignored after the handshake cycle.
- Serial output:
  - START drives so=0.
  - DATA drives so = shift register bit 0, shifting right once every DIV cycles. Bit order is d[0] first, d[WIDTH-1] last.
  - STOP and IDLE drive so=1.
- Counters:
  - Cycle-per-bit counter: width $clog2(DIV+1).
  - Bit counter: width $clog2(WIDTH+1).
  - Both clear on entering each state.
  - Neither wraps beyond its terminal count.
- Reset values (rst_n low at a clock edge):
  - so=1, so_valid=0, busy=0, grant_id=0, state IDLE, pointer=1.
  - Shift register cleared; both readys low while rst_n is low.
- Reset mid-frame: the frame is aborted and the word discarded. so returns to 1 on the reset edge, with no partial stop bit. The first IDLE cycle after rst_n rises may handshake.

## Timing
- Handshake in cycle T. At edge T+1: so=0, busy=1.
- Data bit k occupies cycles T+1+DIV×(1+k) to T+DIV×(2+k); so_valid=1 throughout.
- Stop bit occupies the last DIV cycles; so=1, so_valid=0, busy=1.
- busy falls at edge T+1+(WIDTH+2)×DIV, which is the first IDLE cycle.
- A ready may assert in that first IDLE cycle.
- Minimum frame-to-frame period is (WIDTH+2)×DIV+1 cycles: exactly one IDLE cycle between back-to-back frames.
- grant_id changes only at handshake edges and holds through the frame and the following IDLE.

## Test plan
- WIDTH=4, DIV=1, req0 only, data 4'b1011 → req0_ready high 1 cycle. so from T+1 is 0,1,1,0,1,1, then idle 1. so_valid=1 for 4 cycles. grant_id=0.
- Both valid continuously, data0=4'hA, data1=4'h5 → grants alternate 0,1,0,1. Serial data bits are 0,1,0,1 then 1,0,1,0. 7-cycle frame spacing.
- DIV=3, req1 data 4'h6 → each bit held 3 cycles. busy high 18 cycles. so_valid high 12 cycles.
- Change req0_data from 4'h3 to 4'hC the cycle after handshake → data bits out are 1,1,0,0 (the 4'h3 word).
- rst_n low for one cycle during data bit 2 → next cycle so=1, busy=0, so_valid=0. A pending req0_valid handshakes in the first cycle after rst_n returns high.
- req1 valid only, back-to-back words → exactly one IDLE cycle (busy=0) between frames. req0_ready stays low throughout.
